// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of one RF write port among NREQ 1-entry writeback buffers; req_valid/req_ready/req_addr/req_data in, registered rf_we/rf_dst_addr/rf_dst/rf_grant_id out, pending bitmap of writes in flight
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_dst_addr,
  output logic [DW-1:0]        rf_dst,
  output logic [1:0]           rf_grant_id,
  output logic [15:0]          pending
);
  logic [NREQ-1:0] full, acc;
  logic [AW-1:0] b_addr [NREQ];
  logic [DW-1:0] b_data [NREQ];
  logic [1:0] ptr, gnt, lo_g, hi_g;
  logic gv, lo_v, hi_v;
  always_comb begin
    req_ready = '0;
    acc = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !rst && !full[i];
      for (int j = 0; j < NREQ; j++) begin
        if (j != i && full[j] && b_addr[j] == req_addr[i*AW +: AW]) req_ready[i] = 1'b0;
        if (j < i && acc[j] && req_addr[j*AW +: AW] == req_addr[i*AW +: AW] && req_addr[i*AW +: AW] != '0) req_ready[i] = 1'b0;
      end
      acc[i] = req_ready[i] && req_valid[i];
    end
  end
  always_comb begin
    lo_v = 1'b0;
    hi_v = 1'b0;
    lo_g = '0;
    hi_g = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (full[i]) begin
        lo_v = 1'b1;
        lo_g = 2'(i);
        if (2'(i) >= ptr) begin
          hi_v = 1'b1;
          hi_g = 2'(i);
        end
      end
    end
    gv = lo_v;
    gnt = hi_v ? hi_g : lo_g;
  end
  always_comb begin
    pending = '0;
    for (int i = 0; i < NREQ; i++)
      if (full[i]) pending[b_addr[i]] = 1'b1;
    if (rf_we) pending[rf_dst_addr] = 1'b1;
    if (rst) pending = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      ptr <= '0;
      rf_we <= 1'b0;
      rf_dst_addr <= '0;
      rf_dst <= '0;
      rf_grant_id <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gv && gnt == 2'(i)) full[i] <= 1'b0;
        if (acc[i] && req_addr[i*AW +: AW] != '0) begin
          full[i] <= 1'b1;
          b_addr[i] <= req_addr[i*AW +: AW];
          b_data[i] <= req_data[i*DW +: DW];
        end
      end
      rf_we <= gv;
      if (gv) begin
        rf_dst_addr <= b_addr[gnt];
        rf_dst <= b_data[gnt];
        rf_grant_id <= gnt;
        ptr <= gnt == 2'(NREQ - 1) ? '0 : gnt + 2'd1;
      end
    end
  end
endmodule
